// File: rtl/banked_dual_port_memory.sv
// banked_dual_port_memory: two valid/ready ports over NUM_BANKS banks, round-robin on same-bank collisions
module banked_dual_port_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_BANKS = 4,
  localparam int BW = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [BW-1:0]         a_bank,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [BW-1:0]         b_bank,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [15:0]           conflict_cnt
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];
  logic conflict, prio, a_acc, b_acc;
  // prio: 0 = port A wins the next collision, 1 = port B
  assign conflict = a_valid & b_valid & (a_bank == b_bank);
  assign a_ready = ~conflict | ~prio;
  assign b_ready = ~conflict | prio;
  assign a_acc = a_valid & a_ready;
  assign b_acc = b_valid & b_ready;
  // storage survives reset; simultaneous accepts always hit different banks
  always_ff @(posedge clk) begin
    if (a_acc & a_we) mem[a_bank][a_addr] <= a_wdata;
    if (b_acc & b_we) mem[b_bank][b_addr] <= b_wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      prio <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      a_rvalid <= a_acc & ~a_we;
      b_rvalid <= b_acc & ~b_we;
      if (a_acc & ~a_we) a_rdata <= mem[a_bank][a_addr];
      if (b_acc & ~b_we) b_rdata <= mem[b_bank][b_addr];
      prio <= conflict ? ~prio : prio;
      conflict_cnt <= (conflict && conflict_cnt != 16'hFFFF) ? conflict_cnt + 16'd1 : conflict_cnt;
    end
  end
endmodule
